// File: rtl/pacman_pkg.sv
// Shared constants for the Pac-Man game state: dot/fruit geometry, scan FSM states
// and the saturating score helper.
package pacman_pkg;

  localparam logic [9:0] SCORE_MAX = 10'd999;

  // 8 x 4 dot grid kept clear of the corner fruit boxes
  localparam logic [9:0] DOT_X [0:31] = '{
    10'd60, 10'd100, 10'd140, 10'd180, 10'd220, 10'd260, 10'd300, 10'd340,
    10'd60, 10'd100, 10'd140, 10'd180, 10'd220, 10'd260, 10'd300, 10'd340,
    10'd60, 10'd100, 10'd140, 10'd180, 10'd220, 10'd260, 10'd300, 10'd340,
    10'd60, 10'd100, 10'd140, 10'd180, 10'd220, 10'd260, 10'd300, 10'd340
  };
  localparam logic [9:0] DOT_Y [0:31] = '{
    10'd60,  10'd60,  10'd60,  10'd60,  10'd60,  10'd60,  10'd60,  10'd60,
    10'd160, 10'd160, 10'd160, 10'd160, 10'd160, 10'd160, 10'd160, 10'd160,
    10'd260, 10'd260, 10'd260, 10'd260, 10'd260, 10'd260, 10'd260, 10'd260,
    10'd360, 10'd360, 10'd360, 10'd360, 10'd360, 10'd360, 10'd360, 10'd360
  };

  // Fruit order: apple, peas, grapes, drink
  localparam logic [9:0] FRUIT_X0 [0:3] = '{10'd12,  10'd371, 10'd12,  10'd370};
  localparam logic [9:0] FRUIT_X1 [0:3] = '{10'd38,  10'd396, 10'd38,  10'd396};
  localparam logic [9:0] FRUIT_Y0 [0:3] = '{10'd10,  10'd10,  10'd414, 10'd413};
  localparam logic [9:0] FRUIT_Y1 [0:3] = '{10'd35,  10'd34,  10'd439, 10'd439};

  typedef enum logic [1:0] {IDLE, SCAN_DOTS, SCAN_FRUITS, CHECK} pt_state_t;

  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [9:0] b,
                                         input logic [9:0] max);
    logic [10:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[9:0];
  endfunction

endpackage

// File: rtl/pellet_tracker_if.sv
// Signal bundle between the game-state tracker and its producer/consumer.
interface pellet_tracker_if #(parameter int N_DOTS = 32);
  logic              frame_clk;
  logic [9:0]        BallX;
  logic [9:0]        BallY;
  logic [9:0]        Ball_size;
  logic              lose;
  logic [9:0]        dX [0:N_DOTS-1];
  logic [9:0]        dY [0:N_DOTS-1];
  logic [N_DOTS-1:0] dots_left;
  logic [3:0]        fruits;
  logic [9:0]        score;
  logic              fruit_eaten;
  logic              win;
  logic              busy;

  modport master (
    output frame_clk, BallX, BallY, Ball_size, lose,
    input  dX, dY, dots_left, fruits, score, fruit_eaten, win, busy
  );

  modport slave (
    input  frame_clk, BallX, BallY, Ball_size, lose,
    output dX, dY, dots_left, fruits, score, fruit_eaten, win, busy
  );
endinterface

// File: rtl/pellet_tracker_box_hit.sv
// Closed-interval overlap of the ball's box against one object box, evaluated at
// 11 bits so the widened bounds cannot wrap.
module box_hit (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] ball_size,
  input  logic [9:0] x0,
  input  logic [9:0] x1,
  input  logic [9:0] y0,
  input  logic [9:0] y1,
  output logic       hit
);
  logic [10:0] ball_x_hi, ball_y_hi, x1_wide, y1_wide;

  assign ball_x_hi = {1'b0, ball_x} + {1'b0, ball_size};
  assign ball_y_hi = {1'b0, ball_y} + {1'b0, ball_size};
  assign x1_wide   = {1'b0, x1} + {1'b0, ball_size};
  assign y1_wide   = {1'b0, y1} + {1'b0, ball_size};

  assign hit = (ball_x_hi >= {1'b0, x0}) && ({1'b0, ball_x} <= x1_wide) &&
               (ball_y_hi >= {1'b0, y0}) && ({1'b0, ball_y} <= y1_wide);
endmodule

// File: rtl/pellet_tracker.sv
// Per-frame scan of Pac-Man against every dot and fruit; records eaten objects,
// keeps the saturating score and raises the sticky win flag.
module pellet_tracker #(
  parameter int         N_DOTS    = 32,
  parameter logic [9:0] DOT_PTS   = 10'd1,
  parameter logic [9:0] FRUIT_PTS = 10'd10,
  parameter logic [9:0] SCORE_MAX = pacman_pkg::SCORE_MAX
) (
  input logic             Clk,
  input logic             Reset,
  pellet_tracker_if.slave bus
);
  import pacman_pkg::*;

  localparam int IW = $clog2(N_DOTS);

  pt_state_t         state, state_next;
  logic [IW-1:0]     idx, idx_next;
  logic              frame_q, start;
  logic [9:0]        x0, x1, y0, y1;
  logic              hit, eat_dot, eat_fruit;
  logic [N_DOTS-1:0] dots_left;
  logic [3:0]        fruits;
  logic [9:0]        score;
  logic              fruit_eaten, win;

  assign start = bus.frame_clk & ~frame_q & ~bus.lose & ~win;

  always_comb begin
    x0 = 10'd0;
    x1 = 10'd0;
    y0 = 10'd0;
    y1 = 10'd0;
    case (state)
      SCAN_DOTS: begin
        x0 = DOT_X[idx];
        x1 = DOT_X[idx] + 10'd5;
        y0 = DOT_Y[idx];
        y1 = DOT_Y[idx] + 10'd5;
      end
      SCAN_FRUITS: begin
        x0 = FRUIT_X0[idx[1:0]];
        x1 = FRUIT_X1[idx[1:0]];
        y0 = FRUIT_Y0[idx[1:0]];
        y1 = FRUIT_Y1[idx[1:0]];
      end
      default: begin
        x0 = 10'd0;
        x1 = 10'd0;
        y0 = 10'd0;
        y1 = 10'd0;
      end
    endcase
  end

  box_hit u_box_hit (
    .ball_x   (bus.BallX),
    .ball_y   (bus.BallY),
    .ball_size(bus.Ball_size),
    .x0       (x0),
    .x1       (x1),
    .y0       (y0),
    .y1       (y1),
    .hit      (hit)
  );

  always_comb begin
    state_next = state;
    idx_next   = idx;
    eat_dot    = 1'b0;
    eat_fruit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SCAN_DOTS;
          idx_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      SCAN_DOTS: begin
        eat_dot = hit & ~dots_left[idx];
        if (idx == IW'(N_DOTS - 1)) begin
          state_next = SCAN_FRUITS;
          idx_next   = '0;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      SCAN_FRUITS: begin
        eat_fruit = hit & ~fruits[idx[1:0]];
        if (idx[1:0] == 2'd3) begin
          state_next = CHECK;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // frame_q follows frame_clk even through reset so a held-high frame_clk is not seen as a new edge
  always_ff @(posedge Clk) begin
    frame_q <= bus.frame_clk;
    if (Reset) begin
      state       <= IDLE;
      idx         <= '0;
      dots_left   <= '0;
      fruits      <= 4'd0;
      score       <= 10'd0;
      fruit_eaten <= 1'b0;
      win         <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      fruit_eaten <= eat_fruit;
      if (eat_dot) begin
        dots_left[idx] <= 1'b1;
        score          <= sat_add(score, DOT_PTS, SCORE_MAX);
      end
      if (eat_fruit) begin
        fruits[idx[1:0]] <= 1'b1;
        score            <= sat_add(score, FRUIT_PTS, SCORE_MAX);
      end
      if (state == CHECK && (&dots_left) && (&fruits)) begin
        win <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_DOTS; i++) begin : g_dots
    assign bus.dX[i] = DOT_X[i];
    assign bus.dY[i] = DOT_Y[i];
  end

  assign bus.dots_left   = dots_left;
  assign bus.fruits      = fruits;
  assign bus.score       = score;
  assign bus.fruit_eaten = fruit_eaten;
  assign bus.win         = win;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_pellet_tracker.sv
// Directed bench for pellet_tracker: table of single-frame vectors plus timed
// sequences for latency, saturation, win, reset and dropped-edge behaviour.
module tb_pellet_tracker;
  import pacman_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       lose = 1'b0;
  logic [9:0] bx = 10'd200;
  logic [9:0] by = 10'd200;
  logic [9:0] bs = 10'd4;

  int checks = 0;
  int errors = 0;

  pellet_tracker_if #(.N_DOTS(32)) bus ();
  pellet_tracker_if #(.N_DOTS(32)) bus2 ();

  assign bus.frame_clk  = frame_clk;
  assign bus.BallX      = bx;
  assign bus.BallY      = by;
  assign bus.Ball_size  = bs;
  assign bus.lose       = lose;
  assign bus2.frame_clk = frame_clk;
  assign bus2.BallX     = bx;
  assign bus2.BallY     = by;
  assign bus2.Ball_size = bs;
  assign bus2.lose      = lose;

  pellet_tracker #(.N_DOTS(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  // Heavy dot value so saturation is reachable with only a few dots
  pellet_tracker #(.N_DOTS(32), .DOT_PTS(10'd199)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0]  x, y, s;
    logic [31:0] exp_dots;
    logic [3:0]  exp_fruits;
    logic [9:0]  exp_score;
  } vec_t;

  vec_t vecs [0:5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic place(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
    bx = x;
    by = y;
    bs = s;
  endtask

  // Leaves the bench in cycle 0 of a new scan
  task automatic start_frame();
    frame_clk = 1'b0;
    tick(1);
    frame_clk = 1'b1;
  endtask

  task automatic run_frame();
    start_frame();
    tick(38);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{10'd200, 10'd200, 10'd4,  32'h0000_0000, 4'b0000, 10'd0};
    vecs[1] = '{10'd262, 10'd62,  10'd12, 32'h0000_0020, 4'b0000, 10'd1};
    vecs[2] = '{10'd262, 10'd62,  10'd12, 32'h0000_0020, 4'b0000, 10'd1};
    vecs[3] = '{10'd25,  10'd22,  10'd4,  32'h0000_0020, 4'b0001, 10'd11};
    vecs[4] = '{10'd25,  10'd22,  10'd4,  32'h0000_0020, 4'b0001, 10'd11};
    vecs[5] = '{10'd383, 10'd426, 10'd4,  32'h0000_0020, 4'b1001, 10'd21};

    tick(3);
    Reset = 1'b0;
    tick(1);
    chk("reset_dots", bus.dots_left, 32'h0);
    chk("reset_fruits", {28'h0, bus.fruits}, 32'h0);
    chk("reset_score", {22'h0, bus.score}, 32'h0);
    chk("reset_fe", {31'h0, bus.fruit_eaten}, 32'h0);
    chk("reset_win", {31'h0, bus.win}, 32'h0);
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("dx5", {22'h0, bus.dX[5]}, 32'd260);
    chk("dy31", {22'h0, bus.dY[31]}, 32'd360);

    for (int i = 0; i < 6; i++) begin
      place(vecs[i].x, vecs[i].y, vecs[i].s);
      run_frame();
      chk($sformatf("vec%0d_dots", i), bus.dots_left, vecs[i].exp_dots);
      chk($sformatf("vec%0d_fruits", i), {28'h0, bus.fruits}, {28'h0, vecs[i].exp_fruits});
      chk($sformatf("vec%0d_score", i), {22'h0, bus.score}, {22'h0, vecs[i].exp_score});
      chk($sformatf("vec%0d_busy", i), {31'h0, bus.busy}, 32'h0);
    end

    // Dot 5 is tested in cycle 6 and shows in cycle 7
    do_reset();
    place(10'd262, 10'd62, 10'd12);
    start_frame();
    tick(1);
    chk("t_busy_c1", {31'h0, bus.busy}, 32'h1);
    tick(5);
    chk("t_dots_c6", bus.dots_left, 32'h0);
    tick(1);
    chk("t_dots_c7", bus.dots_left, 32'h20);
    chk("t_score_c7", {22'h0, bus.score}, 32'd1);
    tick(30);
    chk("t_busy_c37", {31'h0, bus.busy}, 32'h1);
    tick(1);
    chk("t_busy_c38", {31'h0, bus.busy}, 32'h0);

    // Apple pulse only in cycle 34
    do_reset();
    place(10'd25, 10'd22, 10'd4);
    start_frame();
    tick(33);
    chk("fe_c33", {31'h0, bus.fruit_eaten}, 32'h0);
    tick(1);
    chk("fe_c34", {31'h0, bus.fruit_eaten}, 32'h1);
    chk("apple_fruits", {28'h0, bus.fruits}, 32'h1);
    chk("apple_score", {22'h0, bus.score}, 32'd10);
    tick(1);
    chk("fe_c35", {31'h0, bus.fruit_eaten}, 32'h0);
    tick(3);

    // Saturation: dut2 reaches 995 after five dots
    do_reset();
    for (int i = 0; i < 5; i++) begin
      place(DOT_X[i] + 10'd2, DOT_Y[i] + 10'd2, 10'd2);
      run_frame();
    end
    chk("sat_995", {22'h0, bus2.score}, 32'd995);
    chk("sat_base5", {22'h0, bus.score}, 32'd5);
    place(10'd25, 10'd22, 10'd4);
    run_frame();
    chk("sat_fruit", {22'h0, bus2.score}, 32'd999);
    chk("sat_base15", {22'h0, bus.score}, 32'd15);
    place(DOT_X[6] + 10'd2, DOT_Y[6] + 10'd2, 10'd2);
    run_frame();
    chk("sat_hold", {22'h0, bus2.score}, 32'd999);
    chk("sat_base16", {22'h0, bus.score}, 32'd16);

    // Eat everything; drink last so win appears in cycle 38 of that scan
    do_reset();
    for (int i = 0; i < 32; i++) begin
      place(DOT_X[i] + 10'd2, DOT_Y[i] + 10'd2, 10'd2);
      run_frame();
    end
    place(10'd25, 10'd22, 10'd2);
    run_frame();
    place(10'd383, 10'd22, 10'd2);
    run_frame();
    place(10'd25, 10'd426, 10'd2);
    run_frame();
    chk("all_dots", bus.dots_left, 32'hFFFF_FFFF);
    chk("pre_win", {31'h0, bus.win}, 32'h0);
    chk("pre_score", {22'h0, bus.score}, 32'd62);
    place(10'd383, 10'd426, 10'd2);
    start_frame();
    tick(37);
    chk("win_c37", {31'h0, bus.win}, 32'h0);
    tick(1);
    chk("win_c38", {31'h0, bus.win}, 32'h1);
    chk("win_fruits", {28'h0, bus.fruits}, 32'hF);
    chk("win_score", {22'h0, bus.score}, 32'd72);
    start_frame();
    tick(1);
    chk("win_noscan_c1", {31'h0, bus.busy}, 32'h0);
    tick(5);
    chk("win_noscan_c6", {31'h0, bus.busy}, 32'h0);
    chk("win_sticky", {31'h0, bus.win}, 32'h1);
    Reset = 1'b1;
    tick(1);
    chk("win_cleared", {31'h0, bus.win}, 32'h0);
    Reset = 1'b0;
    tick(1);

    // lose blocks scan start
    lose = 1'b1;
    place(10'd62, 10'd62, 10'd2);
    start_frame();
    tick(2);
    chk("lose_busy", {31'h0, bus.busy}, 32'h0);
    tick(38);
    chk("lose_dots", bus.dots_left, 32'h0);
    lose = 1'b0;

    // Reset in cycle 15 of a scan
    start_frame();
    tick(15);
    chk("mid_busy", {31'h0, bus.busy}, 32'h1);
    chk("mid_dots", bus.dots_left, 32'h1);
    Reset = 1'b1;
    tick(1);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_dots", bus.dots_left, 32'h0);
    chk("rst_score", {22'h0, bus.score}, 32'd0);
    chk("rst_fruits", {28'h0, bus.fruits}, 32'h0);
    Reset = 1'b0;
    tick(3);
    chk("rst_idle", {31'h0, bus.busy}, 32'h0);

    // A frame edge in the middle of a scan is dropped
    place(10'd102, 10'd62, 10'd2);
    start_frame();
    tick(10);
    frame_clk = 1'b0;
    tick(1);
    frame_clk = 1'b1;
    tick(27);
    chk("drop_busy_c38", {31'h0, bus.busy}, 32'h0);
    chk("drop_dots", bus.dots_left, 32'h2);
    chk("drop_score", {22'h0, bus.score}, 32'd1);
    tick(3);
    chk("drop_busy_c41", {31'h0, bus.busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pellet_tracker.md
# pellet_tracker

Game-state stage directly upstream of `color_mapper`. Once per frame it tests Pac-Man's position against the 32 dot positions and the 4 corner fruits. It records what has been eaten and keeps the score. It drives the `dX`/`dY`, `dots_left`, `fruits`, `score` and `win` inputs that `color_mapper` consumes.

## Interface
- `N_DOTS`, 32: number of dots; sets the width of `dots_left` and the depth of `dX`/`dY`.
- `DOT_PTS`, 1: score added per dot.
- `FRUIT_PTS`, 10: score added per fruit.
- `SCORE_MAX`, 999: score saturation value (three displayed digits).

Ports:
- `Clk`  in  1: system clock.
- `Reset`  in  1: synchronous, active-high reset.
- `frame_clk`  in  1: frame-rate signal, synchronous to `Clk`; a rising edge starts one scan.
- `BallX`, `BallY`  in  10: Pac-Man centre.
- `Ball_size`  in  10: Pac-Man half-size.
- `lose`  in  1: game lost; while high, no scan starts.
- `dX`, `dY`  out  10 x [0:N_DOTS-1]: dot top-left corners, constant from package tables.
- `dots_left`  out  N_DOTS: bit 1 = dot eaten, bit 0 = dot present.
- `fruits`  out  4: bit 1 = fruit eaten; bit order is apple, peas, grapes, drink.
- `score`  out  10: running score.
- `fruit_eaten`  out  1: one-cycle pulse when any fruit is collected.
- `win`  out  1: sticky; all dots and all fruits eaten.
- `busy`  out  1: high while a scan is running.

## Operation
- Reset values: `dots_left`=0, `fruits`=0, `score`=0, `fruit_eaten`=0, `win`=0, `busy`=0, state=IDLE.
- Edge detect: `frame_q` holds `frame_clk` registered. A start is `frame_clk & ~frame_q`; it is honoured only in IDLE with `lose`=0 and `win`=0.
- FSM states:
  - IDLE -> SCAN_DOTS on a start; `idx` is set to 0.
  - SCAN_DOTS: tests dot `idx` each cycle. After `idx`=N_DOTS-1 -> SCAN_FRUITS with `idx`=0.
  - SCAN_FRUITS: tests fruit `idx` each cycle. After `idx`=3 -> CHECK.
  - CHECK: sets `win` if `&dots_left && &fruits`, then -> IDLE.
- Hit test uses closed-interval bounding-box overlap, computed at 11 bits unsigned so no term underflows. Object box is [x0,x1] x [y0,y1].
  - Hit when `BallX+Ball_size >= x0`, `BallX <= x1+Ball_size`, and the same two conditions hold in Y.
- Dot box is (`dX[i]`..`dX[i]+5`, `dY[i]`..`dY[i]+5`).
- Fruit boxes:
  - Apple: (12..38, 10..35).
  - Peas: (371..396, 10..34).
  - Grapes: (12..38, 414..439).
  - Drink: (370..396, 413..439).
- On a hit against an object not yet eaten:
  - The object's bit is set.
  - `score` = min(`score`+PTS, SCORE_MAX).
  - For fruits, `fruit_eaten` pulses for one cycle.
- A hit against an already-eaten object changes nothing; no score and no pulse.
- Score saturates at SCORE_MAX; it never wraps.

## Timing
- Cycle 0: the start edge is seen in IDLE. `busy` rises in cycle 1.
- Cycles 1..32 test dots 0..31; cycles 33..36 test fruits 0..3; cycle 37 is CHECK.
- Every bit, `score` and `fruit_eaten` update is registered and visible one cycle after the test cycle that caused it.
- `win` is visible from cycle 38. `busy` falls in the cycle after CHECK. Total scan latency is 38 cycles, well inside one frame.
- A `frame_clk` edge that arrives during a scan is dropped; it is not queued.
- `lose` rising mid-scan does not abort; the current scan completes.
- `Reset` mid-scan returns to IDLE and clears every output in the following cycle.
- `dX`/`dY` are combinational constants with zero latency, unaffected by reset.

## Structure
- `pacman_pkg` holds:
  - `DOT_X`/`DOT_Y` constant arrays.
  - Fruit box constants `FRUIT_X0/X1/Y0/Y1[0:3]`.
  - State typedef `pt_state_t` (IDLE, SCAN_DOTS, SCAN_FRUITS, CHECK).
  - `SCORE_MAX`.
- Sub-module `box_hit`: purely combinational overlap test. Inputs: ball x/y/size and the box x0/x1/y0/y1. Output: `hit`. It is instantiated once and muxed by state and `idx`.

## Test plan
- Reset, then Ball at (200,200), which is clear of all objects, with one frame edge -> after 38 cycles `dots_left`=0, `score`=0, `busy`=0.
- Ball at (`DOT_X[5]`+2, `DOT_Y[5]`+2) with `Ball_size`=12, one edge -> `dots_left`=32'h20 and `score`=1 at cycle 7. A second frame in the same position -> `score` stays 1.
- Ball at (25,22), one edge -> `fruits`=4'b0001, `score`=10, and `fruit_eaten` high for exactly one cycle at cycle 34.
- Preload `score`=995 by eating dots, then eat a fruit -> `score`=999. Eat a further dot -> `score` stays 999.
- Eat all 32 dots and 4 fruits -> `win`=1 at cycle 38 of the final scan. Later edges produce no scan (`busy` stays 0). `win` clears only on `Reset`.
- Assert `Reset` at cycle 15 of a scan -> in the next cycle every output is 0 and the state is IDLE. Pulsing `frame_clk` during a scan -> no second scan.
